// File: rtl/queue_push_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : queue_push_ctrl
// Brief   : Two-entry skid buffer feeding a queue's push port, with
//           saturating push and stall statistics counters.
// Revision: 1.0 - initial release
// ============================================================================
module queue_push_ctrl #(
  parameter int DW = 6,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          q_full,
  output logic          q_push,
  output logic [DW-1:0] q_data,
  input  logic          clr_cnt,
  output logic [CW-1:0] push_cnt,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
  localparam logic [CW-1:0] c_cnt_one = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic [CW-1:0] r_push_cnt;
  logic [CW-1:0] r_stall_cnt;

  logic w_accept;
  logic w_push;
  logic w_stall;

  // in_ready depends only on the state flops; q_full reaches only q_push.
  assign in_ready = (r_state != S_TWO);
  assign w_accept = in_valid & in_ready;
  assign w_push   = (r_state != S_EMPTY) & ~q_full;
  assign w_stall  = (r_state != S_EMPTY) & q_full;

  assign q_push    = w_push;
  assign q_data    = r_head;
  assign push_cnt  = r_push_cnt;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state <= S_ONE;
            r_head  <= in_data;
          end
        end
        S_ONE: begin
          if (w_accept && w_push) begin
            r_head <= in_data;
          end else if (w_accept) begin
            r_state <= S_TWO;
            r_tail  <= in_data;
          end else if (w_push) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_push) begin
            r_state <= S_ONE;
            r_head  <= r_tail;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_push_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (clr_cnt) begin
      r_push_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push && (r_push_cnt != c_cnt_max)) begin
        r_push_cnt <= r_push_cnt + c_cnt_one;
      end
      if (w_stall && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire
